// File: rtl/serial_frame_shifter_pkg.sv
// Shared types and constants for the MUX serial link shifters.
package mux_serial_pkg;

    localparam int MAX_FRAME_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } frame_state_t;

    // Bit-counter width for a frame of 'width' bits (at least one bit).
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_frame_shifter_if.sv
// Load/receive handshake and serial pins of one shifter; master drives, slave is the shifter.
interface serial_frame_shifter_if #(
    parameter int WIDTH = 5
);
    logic             loadValid;
    logic             loadReady;
    logic [WIDTH-1:0] txData;
    logic             bitStrobe;
    logic             abort;
    logic             sdi;
    logic             sdo;
    logic             busy;
    logic [WIDTH-1:0] rxData;
    logic             rxValid;

    modport master (
        output loadValid, txData, bitStrobe, abort, sdi,
        input  loadReady, sdo, busy, rxData, rxValid
    );

    modport slave (
        input  loadValid, txData, bitStrobe, abort, sdi,
        output loadReady, sdo, busy, rxData, rxValid
    );
endinterface

// File: rtl/serial_frame_shifter_shift_core.sv
// Transmit/receive shift register pair; load has priority over shift, one bit per shift.
// load_bit/next_bit give the bit the owner should drive on sdo after a load/shift.
module serial_shift_core #(
    parameter int WIDTH     = 5,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] tx_word,
    input  logic             sdi,
    output logic             load_bit,
    output logic             next_bit,
    output logic [WIDTH-1:0] rx_word
);
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] rx_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift <= '0;
            rx_shift <= '0;
        end else if (load) begin
            tx_shift <= tx_word;
            rx_shift <= '0;
        end else if (shift) begin
            if (LSB_FIRST) begin
                tx_shift <= tx_shift >> 1;
                rx_shift <= {sdi, rx_shift[WIDTH-1:1]};
            end else begin
                tx_shift <= tx_shift << 1;
                rx_shift <= {rx_shift[WIDTH-2:0], sdi};
            end
        end
    end

    // The head of tx_shift is the bit currently on sdo; the one behind it goes out next.
    assign load_bit = LSB_FIRST ? tx_word[0]  : tx_word[WIDTH-1];
    assign next_bit = LSB_FIRST ? tx_shift[1] : tx_shift[WIDTH-2];
    assign rx_word  = rx_shift;

endmodule

// File: rtl/serial_frame_shifter.sv
// Full-duplex frame shifter: rxValid pulses 2 cycles after the last bitStrobe edge.
// loadReady only in IDLE; loadValid is ignored while a frame is in flight.
module serial_frame_shifter
    import mux_serial_pkg::*;
#(
    parameter int WIDTH      = 5,
    parameter bit LSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input logic                   CLK,
    input logic                   reset_n,
    serial_frame_shifter_if.slave bus
);
    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    frame_state_t     state;
    frame_state_t     state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic             sdo_q;
    logic             rx_valid_q;
    logic [WIDTH-1:0] rx_data_q;
    logic             accept;
    logic             shift_en;
    logic             last_bit;
    logic             load_bit;
    logic             next_bit;
    logic [WIDTH-1:0] rx_word;

    assign last_bit = (bit_cnt == LAST_BIT);

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort outranks both a new load and a bit strobe.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        shift_en  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.loadValid && !bus.abort) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (bus.bitStrobe) begin
                    shift_en = 1'b1;
                    if (last_bit) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt    <= '0;
            sdo_q      <= IDLE_LEVEL;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (accept) begin
                bit_cnt <= '0;
                sdo_q   <= load_bit;
            end else if (shift_en) begin
                if (last_bit) begin
                    bit_cnt <= '0;
                    sdo_q   <= IDLE_LEVEL;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    sdo_q   <= next_bit;
                end
            end else if (state_nxt == IDLE) begin
                bit_cnt <= '0;
                sdo_q   <= IDLE_LEVEL;
            end
            if (state == DONE && !bus.abort) begin
                rx_data_q  <= rx_word;
                rx_valid_q <= 1'b1;
            end
        end
    end

    serial_shift_core #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_core (
        .clk      (CLK),
        .rst_n    (reset_n),
        .load     (accept),
        .shift    (shift_en),
        .tx_word  (bus.txData),
        .sdi      (bus.sdi),
        .load_bit (load_bit),
        .next_bit (next_bit),
        .rx_word  (rx_word)
    );

    assign bus.loadReady = (state == IDLE);
    assign bus.busy      = (state == SHIFT) || (state == DONE);
    assign bus.sdo       = sdo_q;
    assign bus.rxData    = rx_data_q;
    assign bus.rxValid   = rx_valid_q;

endmodule
